// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer band scheduler.
// EQ_SAT_EN (optional define) selects a saturated output sum instead of a wrapped one.
package eq_pkg;

    localparam int NUM_BANDS = 8;
    localparam int DW        = 16;
    localparam int ACC_W     = DW + 3;

    // Q2.14 representation of 1.0
    localparam logic [DW-1:0] UNITY_GAIN = 16'h4000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_OUT
    } state_t;

endpackage

// File: rtl/eq_gain_bank.sv
// Shadow/active per-band gain storage. Software writes the shadow copy at any time;
// the active copy only changes when the scheduler starts a new sample with a commit pending.
module eq_gain_bank #(
    parameter int NUM_BANDS = eq_pkg::NUM_BANDS,
    parameter int DW        = eq_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    input  logic          apply,
    input  logic [2:0]    rd_idx,
    output logic [DW-1:0] rd_gain,
    output logic          commit_pend
);
    import eq_pkg::*;

    logic [DW-1:0] shadow [NUM_BANDS];
    logic [DW-1:0] active [NUM_BANDS];
    logic          do_copy;

    // A commit raised in the accepting cycle itself is honoured immediately.
    assign do_copy = apply && (commit_pend || commit);

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_pend <= 1'b0;
            // NOTE: the gain arrays are reset because unity gain must be valid from the first sample.
            for (int i = 0; i < NUM_BANDS; i++) begin
                shadow[i] <= DW'(UNITY_GAIN);
                active[i] <= DW'(UNITY_GAIN);
            end
        end else begin
            if (do_copy) begin
                commit_pend <= 1'b0;
            end else if (commit) begin
                commit_pend <= 1'b1;
            end
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (wr_en && wr_addr == 3'(i)) begin
                    shadow[i] <= wr_data;
                end
                // Forward a same-cycle write so it is part of the copy.
                if (do_copy) begin
                    active[i] <= (wr_en && wr_addr == 3'(i)) ? wr_data : shadow[i];
                end
            end
        end
    end

    always_comb begin
        // NOTE: default assignment first so the read mux cannot infer a latch.
        rd_gain = '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_gain = active[i];
            end
        end
    end

endmodule

// File: rtl/eq_band_scheduler.sv
// Issues each input sample to a shared filter/gain unit once per band and sums the returns.
// Define EQ_SAT_EN to saturate m_y to the DW-bit signed range; otherwise it wraps.
module eq_band_scheduler #(
    parameter int NUM_BANDS = eq_pkg::NUM_BANDS,
    parameter int DW        = eq_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_x,
    input  logic          g_wr_en,
    input  logic [2:0]    g_wr_addr,
    input  logic [DW-1:0] g_wr_data,
    input  logic          g_commit,
    output logic          band_valid,
    output logic [2:0]    band_idx,
    output logic [DW-1:0] band_x,
    output logic [DW-1:0] band_gain,
    input  logic          r_valid,
    input  logic [DW-1:0] r_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_y,
    output logic          busy,
    output logic          commit_pend,
    output logic          err
);
    import eq_pkg::*;

    localparam int SUM_W = DW + (eq_pkg::ACC_W - eq_pkg::DW);
    localparam int CNT_W = $clog2(NUM_BANDS + 1);

    state_t                   state;
    logic signed [SUM_W-1:0]  acc;
    logic signed [SUM_W-1:0]  acc_next;
    logic signed [SUM_W-1:0]  r_ext;
    logic [CNT_W-1:0]         ret_cnt;
    logic [CNT_W-1:0]         cnt_next;
    logic                     accept;
    logic                     ret_ok;
    logic                     ret_bad;
    logic [DW-1:0]            y_next;

    assign accept  = (state == S_IDLE) && s_valid;
    assign busy    = (state != S_IDLE);

    // Returns are counted, not matched to a band; anything past NUM_BANDS is a protocol error.
    assign ret_ok  = r_valid && (state == S_ISSUE || state == S_DRAIN)
                     && (ret_cnt < CNT_W'(NUM_BANDS));
    assign ret_bad = r_valid && !ret_ok;

    assign r_ext    = {{(SUM_W-DW){r_data[DW-1]}}, r_data};
    assign acc_next = ret_ok ? acc + r_ext : acc;
    assign cnt_next = ret_ok ? ret_cnt + CNT_W'(1) : ret_cnt;

`ifdef EQ_SAT_EN
    localparam logic signed [SUM_W-1:0] Y_MAX = {{(SUM_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] Y_MIN = {{(SUM_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        y_next = acc_next[DW-1:0];
        if (acc_next > Y_MAX) begin
            y_next = Y_MAX[DW-1:0];
        end else if (acc_next < Y_MIN) begin
            y_next = Y_MIN[DW-1:0];
        end
    end
`else
    assign y_next = acc_next[DW-1:0];
`endif

    eq_gain_bank #(
        .NUM_BANDS (NUM_BANDS),
        .DW        (DW)
    ) u_gain_bank (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (g_wr_en),
        .wr_addr     (g_wr_addr),
        .wr_data     (g_wr_data),
        .commit      (g_commit),
        .apply       (accept),
        .rd_idx      (band_idx),
        .rd_gain     (band_gain),
        .commit_pend (commit_pend)
    );

    // NOTE: all state here is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            s_ready    <= 1'b1;
            band_valid <= 1'b0;
            band_idx   <= '0;
            band_x     <= '0;
            m_valid    <= 1'b0;
            m_y        <= '0;
            acc        <= '0;
            ret_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            if (ret_bad) begin
                err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_ISSUE;
                        s_ready    <= 1'b0;
                        band_valid <= 1'b1;
                        band_idx   <= '0;
                        band_x     <= s_x;
                        acc        <= '0;
                        ret_cnt    <= '0;
                    end
                end
                S_ISSUE: begin
                    acc     <= acc_next;
                    ret_cnt <= cnt_next;
                    if (band_idx == 3'(NUM_BANDS - 1)) begin
                        band_valid <= 1'b0;
                        state      <= S_DRAIN;
                    end else begin
                        band_idx <= band_idx + 3'd1;
                    end
                end
                S_DRAIN: begin
                    acc     <= acc_next;
                    ret_cnt <= cnt_next;
                    if (cnt_next == CNT_W'(NUM_BANDS)) begin
                        state   <= S_OUT;
                        m_valid <= 1'b1;
                        m_y     <= y_next;
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        state   <= S_IDLE;
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Directed scoreboard bench for eq_band_scheduler: stimulus queues expected band issues and
// output sums, a negedge monitor pops and compares them whenever the DUT presents them.
module tb_eq_band_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_x = '0;
    logic        g_wr_en = 1'b0;
    logic [2:0]  g_wr_addr = '0;
    logic [15:0] g_wr_data = '0;
    logic        g_commit = 1'b0;
    logic        band_valid;
    logic [2:0]  band_idx;
    logic [15:0] band_x;
    logic [15:0] band_gain;
    logic        r_valid = 1'b0;
    logic [15:0] r_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_y;
    logic        busy;
    logic        commit_pend;
    logic        err;

    typedef logic [15:0] rd_t [8];

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] gain;
        logic [15:0] x;
    } band_exp_t;

    band_exp_t   band_q[$];
    logic [15:0] y_q[$];
    logic [15:0] exp_gain [8];

    int n_pass  = 0;
    int n_total = 0;

    eq_band_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_x         (s_x),
        .g_wr_en     (g_wr_en),
        .g_wr_addr   (g_wr_addr),
        .g_wr_data   (g_wr_data),
        .g_commit    (g_commit),
        .band_valid  (band_valid),
        .band_idx    (band_idx),
        .band_x      (band_x),
        .band_gain   (band_gain),
        .r_valid     (r_valid),
        .r_data      (r_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_y         (m_y),
        .busy        (busy),
        .commit_pend (commit_pend),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every band issue and every output handshake against the queues.
    initial begin
        band_exp_t e;
        forever begin
            @(negedge clk);
            if (band_valid === 1'b1) begin
                if (band_q.size() == 0) begin
                    check("band_unexpected", 32'(band_valid), 32'd0);
                end else begin
                    e = band_q.pop_front();
                    check("band_idx",  32'(band_idx),  32'(e.idx));
                    check("band_gain", 32'(band_gain), 32'(e.gain));
                    check("band_x",    32'(band_x),    32'(e.x));
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (y_q.size() == 0) begin
                    check("m_unexpected", 32'(m_valid), 32'd0);
                end else begin
                    check("m_y", 32'(m_y), 32'(y_q.pop_front()));
                end
            end
        end
    end

    // One full sample: returns arrive one cycle after each band issue.
    task automatic run_sample(input logic [15:0] x, input rd_t rd, input logic [15:0] y,
                              input bit extra, input int hold, input int wr_cyc,
                              input logic [15:0] wr_val);
        int guard = 0;
        while (s_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("s_ready_idle", 32'(s_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            band_q.push_back('{idx: 3'(i), gain: exp_gain[i], x: x});
        end
        y_q.push_back(y);
        s_valid = 1'b1;
        s_x     = x;
        tick();
        s_valid = 1'b0;
        s_x     = '0;
        for (int c = 0; c <= 8; c++) begin
            r_valid   = (c >= 1);
            r_data    = (c >= 1) ? rd[c-1] : 16'd0;
            g_wr_en   = (c == wr_cyc);
            g_commit  = (c == wr_cyc);
            g_wr_addr = 3'd3;
            g_wr_data = wr_val;
            if (c == 8) begin
                check("no_early_m_valid", 32'(m_valid), 32'd0);
            end
            tick();
            if (c == wr_cyc) begin
                check("commit_pend_set", 32'(commit_pend), 32'd1);
            end
        end
        r_valid  = 1'b0;
        g_wr_en  = 1'b0;
        g_commit = 1'b0;
        check("latency_m_valid", 32'(m_valid), 32'd1);
        if (hold > 0) begin
            m_ready = 1'b0;
            s_valid = 1'b1;
            s_x     = 16'h7777;
            for (int h = 0; h < hold; h++) begin
                tick();
                check("hold_m_valid", 32'(m_valid), 32'd1);
                check("hold_m_y",     32'(m_y),     32'(y));
                check("hold_s_ready", 32'(s_ready), 32'd0);
            end
            s_valid = 1'b0;
            s_x     = '0;
            m_ready = 1'b1;
        end
        if (extra) begin
            r_valid = 1'b1;
            r_data  = 16'h1234;
        end
        tick();
        r_valid = 1'b0;
        check("back_to_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) exp_gain[i] = 16'h4000;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_s_ready",     32'(s_ready),     32'd1);
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_band_valid",  32'(band_valid),  32'd0);
        check("rst_m_valid",     32'(m_valid),     32'd0);
        check("rst_err",         32'(err),         32'd0);
        check("rst_commit_pend", 32'(commit_pend), 32'd0);
        check("rst_m_y",         32'(m_y),         32'd0);
        check("rst_band_idx",    32'(band_idx),    32'd0);
        check("rst_band_x",      32'(band_x),      32'd0);
        check("rst_band_gain",   32'(band_gain),   32'h4000);

        // 8 x 1000 = 8000
        run_sample(16'd100, '{default: 16'd1000}, 16'd8000, 1'b0, 0, -1, 16'd0);
        check("err_clean", 32'(err), 32'd0);

        // 8 x 0x7000 overflows the output range
`ifdef EQ_SAT_EN
        run_sample(16'd5, '{default: 16'h7000}, 16'h7FFF, 1'b0, 0, -1, 16'd0);
`else
        run_sample(16'd5, '{default: 16'h7000}, 16'h8000, 1'b0, 0, -1, 16'd0);
`endif

        // mixed signs: -5+10-20+40+3-1+0+7 = 34
        run_sample(16'hFF00, '{16'hFFFB, 16'd10, 16'hFFEC, 16'd40, 16'd3, 16'hFFFF, 16'd0, 16'd7},
                   16'd34, 1'b0, 0, -1, 16'd0);

        // 8 x -16384 = -131072: saturates negative, wraps to zero
`ifdef EQ_SAT_EN
        run_sample(16'd7, '{default: 16'hC000}, 16'h8000, 1'b0, 0, -1, 16'd0);
`else
        run_sample(16'd7, '{default: 16'hC000}, 16'h0000, 1'b0, 0, -1, 16'd0);
`endif

        // gain write + commit during ISSUE: this sample still unity on band 3
        run_sample(16'd11, '{default: 16'd1}, 16'd8, 1'b0, 0, 2, 16'h2000);
        check("commit_pend_held", 32'(commit_pend), 32'd1);
        exp_gain[3] = 16'h2000;
        run_sample(16'd12, '{default: 16'd5}, 16'd40, 1'b0, 0, -1, 16'd0);
        check("commit_pend_clear", 32'(commit_pend), 32'd0);

        // 9th return is ignored but flags err
        run_sample(16'd13, '{default: 16'd3}, 16'd24, 1'b1, 0, -1, 16'd0);
        check("err_extra_return", 32'(err), 32'd1);

        r_valid = 1'b1;
        r_data  = 16'd99;
        tick();
        r_valid = 1'b0;
        check("err_idle_return", 32'(err), 32'd1);

        // output back-pressure for 5 cycles
        run_sample(16'd14, '{default: 16'd2}, 16'd16, 1'b0, 5, -1, 16'd0);
        check("err_sticky", 32'(err), 32'd1);

        // reset while band 4 is being issued
        for (int i = 0; i < 8; i++) begin
            band_q.push_back('{idx: 3'(i), gain: exp_gain[i], x: 16'd15});
        end
        s_valid = 1'b1;
        s_x     = 16'd15;
        tick();
        s_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check("mid_band_idx", 32'(band_idx), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        band_q.delete();
        check("mid_rst_busy",       32'(busy),        32'd0);
        check("mid_rst_s_ready",    32'(s_ready),     32'd1);
        check("mid_rst_band_valid", 32'(band_valid),  32'd0);
        check("mid_rst_err",        32'(err),         32'd0);
        check("mid_rst_gain0",      32'(band_gain),   32'h4000);
        r_valid = 1'b1;
        r_data  = 16'd50;
        tick();
        r_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("mid_rst_no_m_valid", 32'(m_valid), 32'd0);
        end
        check("late_return_err", 32'(err), 32'd1);

        for (int i = 0; i < 8; i++) exp_gain[i] = 16'h4000;
        run_sample(16'd16, '{default: 16'd4}, 16'd32, 1'b0, 0, -1, 16'd0);

        tick();
        check("band_q_empty", 32'(band_q.size()), 32'd0);
        check("y_q_empty",    32'(y_q.size()),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eq_band_scheduler.md
EQ_BAND_SCHEDULER -- requirements
Module: eq_band_scheduler

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 8, number of equalizer bands issued per sample.
REQ-002 SHALL have parameter DW, default 16, sample and gain width.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous and active-high.
REQ-004 SHALL have ports: s_valid in 1, input sample valid; s_ready out 1, scheduler can accept; s_x in DW, signed input sample.
REQ-005 SHALL have ports: g_wr_en in 1, shadow gain write; g_wr_addr in 3, band index; g_wr_data in DW, gain (Q2.14); g_commit in 1, request shadow-to-active copy.
REQ-006 SHALL have ports: band_valid out 1, issue strobe to shared filter/gain unit; band_idx out 3, band selected; band_x out DW, latched sample; band_gain out DW, active gain of band_idx.
REQ-007 SHALL have ports: r_valid in 1, band result valid; r_data in DW, signed gained band output.
REQ-008 SHALL have ports: m_valid out 1, output valid; m_ready in 1, sink ready; m_y out DW, signed equalized sample.
REQ-009 SHALL have ports: busy out 1, not in IDLE; commit_pend out 1, commit requested, not yet applied; err out 1, sticky protocol error.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, DRAIN, OUT.
REQ-011 IDLE: s_ready=1; on s_valid, latch s_x, clear accumulator and counters, apply pending commit, go to ISSUE.
REQ-012 ISSUE: band_valid=1 every cycle, band_idx 0 to NUM_BANDS-1, one per cycle; after idx NUM_BANDS-1, go to DRAIN.
REQ-013 r_valid SHALL be accepted in ISSUE and DRAIN; each accepted r_data is sign-extended and added to an accumulator DW+3 bits wide; return counter increments.
REQ-014 DRAIN: when return count reaches NUM_BANDS (including a return in the same cycle), go to OUT the next cycle.
REQ-015 OUT: m_valid=1, m_y held stable until m_ready; on m_valid and m_ready, go to IDLE; s_ready SHALL stay 0 in OUT.
REQ-016 Minimum sample-to-output latency SHALL be NUM_BANDS+1 cycles from s_valid acceptance to m_valid, with zero-latency returns.
REQ-017 g_wr_en SHALL write the shadow gain array in any state; active gains SHALL change only on the IDLE-to-ISSUE transition.
REQ-018 g_commit SHALL set commit_pend; commit_pend clears when the copy occurs; a write and commit in the same cycle as acceptance SHALL include that write in the copy.
REQ-019 r_valid in IDLE or OUT, or a return beyond NUM_BANDS, SHALL be ignored and set err; err clears only on reset.
REQ-020 Returns SHALL be order-agnostic; the scheduler sums without checking band identity.

Reset
REQ-021 On rst: state IDLE; s_ready=1 from the first cycle after reset; band_valid, m_valid, err, commit_pend=0; m_y, band_x, band_idx, accumulator, counters=0.
REQ-022 On rst: active and shadow gains SHALL all be 16'h4000 (unity).
REQ-023 rst mid-operation SHALL abandon the in-flight sample with no m_valid; later late returns set err.

Configuration
REQ-024 With macro EQ_SAT_EN defined, m_y SHALL be the accumulator saturated to [-32768, 32767].
REQ-025 Without EQ_SAT_EN, m_y SHALL be the low DW bits of the accumulator (two's-complement wrap).

Structure
REQ-026 A package eq_pkg SHALL hold the FSM state enum, NUM_BANDS, DW, the unity-gain constant, and the accumulator width.
REQ-027 A sub-module eq_gain_bank SHALL hold the shadow/active gain arrays, commit logic, and read port for band_gain.

Verification
REQ-028 Reset, then s_x=100 with all returns r_data=1000 issued the cycle after each band_valid; m_y=8000 and band_gain=16'h4000 on all bands.
REQ-029 EQ_SAT_EN: eight returns of 16'h7000; m_y=32767. Without the macro, m_y is the low 16 bits of 8*16'h7000, giving 16'h8000.
REQ-030 Write gain band 3=16'h2000 and commit while in ISSUE; the current sample still shows 16'h4000 for band 3, and the next sample shows 16'h2000; commit_pend is 1 between commit and application, then 0.
REQ-031 Hold m_ready=0 for 5 cycles in OUT; m_y stays stable, s_ready=0, and s_valid is not accepted; m_ready=1 returns to IDLE.
REQ-032 Inject r_valid in IDLE, and send a 9th return for one sample; err=1 stays sticky, and the output sum is unaffected by the extra return.
REQ-033 Assert rst in ISSUE at band 4; no m_valid occurs, the state is IDLE the next cycle, and gains are reset to 16'h4000.
